traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
Passive checker on the {Red, Yellow, Green} light bus driven by the traffic light controller. Samples light every clock, tracks the phase sequence RED -> GREEN -> YELLOW -> RED, checks encoding, order and per-phase dwell against parameter bounds, and reports sticky error flags plus a completed-cycle count. Sits beside the controller in the top level and in the testbench as a protocol reader; it never drives the light bus.

Parameters:
RED_MIN, 4, minimum legal RED dwell in clock samples
RED_MAX, 8, maximum legal RED dwell
GREEN_MIN, 4, minimum legal GREEN dwell
GREEN_MAX, 8, maximum legal GREEN dwell
YELLOW_MIN, 2, minimum legal YELLOW dwell
YELLOW_MAX, 6, maximum legal YELLOW dwell
DW_W, 8, dwell counter width (all MIN/MAX < 2^DW_W - 1)
CNT_W, 16, completed-cycle counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
light  input  3  observed light bus {Red, Yellow, Green}
clear_err  input  1  single-cycle pulse, clears err_status
phase  output  2  tracked phase: 00 RED, 01 GREEN, 10 YELLOW, 11 SYNC
err_status  output  4  sticky {long, short, order, code}
err_pulse  output  1  high for one cycle on any newly detected error
cycle_count  output  CNT_W  completed RED->GREEN->YELLOW->RED cycles, saturating
in_sync  output  1  high when FSM is tracking (not SYNC)

Behaviour:
- Reset values: phase=11 (SYNC), err_status=0, err_pulse=0, cycle_count=0, in_sync=0, dwell counter=0. Reset mid-operation aborts tracking immediately; no error is flagged by reset.
- All outputs registered; decisions use the light value sampled at a rising edge and are visible after that same edge.
- Decode: 100 RED, 001 GREEN, 010 YELLOW; anything else (000, multi-hot) is illegal code.
- FSM states SYNC, RED, GREEN, YELLOW.
- SYNC: ignore GREEN/YELLOW; no order/dwell checks; illegal code sets err code bit. On RED sample -> RED, dwell=1.
- Tracking state, same phase sampled: dwell+1 (saturates at all ones). When dwell would reach MAX+1: set err long once, -> SYNC.
- Tracking state, legal successor sampled: if dwell < MIN of current phase set err short and -> SYNC; else -> successor, dwell=1. YELLOW->RED with no error increments cycle_count (saturating at 2^CNT_W-1).
- Tracking state, wrong legal phase sampled: set err order, -> SYNC.
- Tracking state, illegal code: set err code, -> SYNC.
- After any error, SYNC; a RED sample in the error cycle does not skip SYNC (re-sync starts next RED sample).
- err_pulse=1 in the cycle any err bit is newly set (even if already sticky); only one error per sample (priority code > order > short > long).
- clear_err clears err_status; clear_err together with a new error: new bit set, others cleared.
- in_sync = (phase != 11).

Optional Feature:
TLM_DWELL_LOG_EN: when defined, adds outputs last_dwell [DW_W-1:0] and last_phase [1:0], updated on every legal phase exit (dwell value of the phase just exited), reset to 0. When undefined, ports and registers absent; all other behaviour identical.

Test Plan:
- Reset, then RED x5, GREEN x5, YELLOW x3, RED -> phase follows 00,01,10,00; cycle_count=1; err_status=0; err_pulse never high.
- Reset, then RED x5, YELLOW -> err_status=0010 (order), err_pulse 1 cycle, phase=11, cycle_count=0.
- In GREEN after 2 samples, light=010 -> err_status=0100 (short); next RED x5 re-syncs, in_sync=1.
- Hold RED 9 samples -> err_status=1000 (long) on 9th sample, exactly one err_pulse, phase=11.
- Drive light=110 while in RED with clear_err=1 on same edge, err_status previously 0100 -> err_status=0001.
- Assert reset mid-GREEN -> all outputs reset values immediately, no err_pulse; with TLM_DWELL_LOG_EN after RED x6 then GREEN -> last_dwell=6, last_phase=00.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive protocol checker for the {Red, Yellow, Green} light bus: tracks RED->GREEN->YELLOW->RED,
// flags code/order/dwell violations and counts completed cycles. Optional dwell log: TLM_DWELL_LOG_EN.
module traffic_light_monitor #(
    parameter int unsigned RED_MIN    = 4,
    parameter int unsigned RED_MAX    = 8,
    parameter int unsigned GREEN_MIN  = 4,
    parameter int unsigned GREEN_MAX  = 8,
    parameter int unsigned YELLOW_MIN = 2,
    parameter int unsigned YELLOW_MAX = 6,
    parameter int unsigned DW_W       = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       light,
    input  logic             clear_err,
    output logic [1:0]       phase,
    output logic [3:0]       err_status,
    output logic             err_pulse,
    output logic [CNT_W-1:0] cycle_count,
    output logic             in_sync
`ifdef TLM_DWELL_LOG_EN
    ,
    output logic [DW_W-1:0]  last_dwell,
    output logic [1:0]       last_phase
`endif
);

    localparam int unsigned ERR_CODE  = 0;
    localparam int unsigned ERR_ORDER = 1;
    localparam int unsigned ERR_SHORT = 2;
    localparam int unsigned ERR_LONG  = 3;

    typedef enum logic [1:0] {
        ST_RED    = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10,
        ST_SYNC   = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [3:0]       err_status_d;
    logic             err_pulse_d;
    logic [CNT_W-1:0] cycle_count_d;
    logic             in_sync_d;
    logic [3:0]       new_err;
    logic             cycle_done;
    logic             phase_exit;

    logic             obs_legal;
    state_t           obs;
    logic [DW_W-1:0]  cur_min, cur_max;
    state_t           succ;

    // Decode the sampled light bus; anything not one-hot is illegal.
    always_comb begin
        obs_legal = 1'b1;
        obs       = ST_SYNC;
        case (light)
            3'b100:  obs = ST_RED;
            3'b001:  obs = ST_GREEN;
            3'b010:  obs = ST_YELLOW;
            default: obs_legal = 1'b0;
        endcase
    end

    // Dwell bounds and expected successor for the phase being tracked.
    always_comb begin
        cur_min = '0;
        cur_max = '0;
        succ    = ST_SYNC;
        case (state_q)
            ST_RED: begin
                cur_min = DW_W'(RED_MIN);
                cur_max = DW_W'(RED_MAX);
                succ    = ST_GREEN;
            end
            ST_GREEN: begin
                cur_min = DW_W'(GREEN_MIN);
                cur_max = DW_W'(GREEN_MAX);
                succ    = ST_YELLOW;
            end
            ST_YELLOW: begin
                cur_min = DW_W'(YELLOW_MIN);
                cur_max = DW_W'(YELLOW_MAX);
                succ    = ST_RED;
            end
            default: ;
        endcase
    end

    // Next-state and next-output logic; at most one error class per sample.
    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        new_err    = '0;
        cycle_done = 1'b0;
        phase_exit = 1'b0;

        if (state_q == ST_SYNC) begin
            if (!obs_legal) begin
                new_err[ERR_CODE] = 1'b1;
            end else if (obs == ST_RED) begin
                state_d = ST_RED;
                dwell_d = DW_W'(1);
            end
        end else if (!obs_legal) begin
            new_err[ERR_CODE] = 1'b1;
            state_d           = ST_SYNC;
            dwell_d           = '0;
        end else if (obs == state_q) begin
            if (dwell_q == cur_max) begin
                new_err[ERR_LONG] = 1'b1;
                state_d           = ST_SYNC;
                dwell_d           = '0;
            end else if (dwell_q != {DW_W{1'b1}}) begin
                dwell_d = dwell_q + DW_W'(1);
            end
        end else if (obs == succ) begin
            if (dwell_q < cur_min) begin
                new_err[ERR_SHORT] = 1'b1;
                state_d            = ST_SYNC;
                dwell_d            = '0;
            end else begin
                state_d    = succ;
                dwell_d    = DW_W'(1);
                phase_exit = 1'b1;
                cycle_done = (state_q == ST_YELLOW);
            end
        end else begin
            new_err[ERR_ORDER] = 1'b1;
            state_d            = ST_SYNC;
            dwell_d            = '0;
        end

        err_status_d  = (clear_err ? 4'b0000 : err_status) | new_err;
        err_pulse_d   = |new_err;
        cycle_count_d = cycle_count;
        if (cycle_done && (cycle_count != {CNT_W{1'b1}})) begin
            cycle_count_d = cycle_count + CNT_W'(1);
        end
        in_sync_d = (state_d != ST_SYNC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SYNC;
            dwell_q     <= '0;
            err_status  <= '0;
            err_pulse   <= 1'b0;
            cycle_count <= '0;
            in_sync     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            err_status  <= err_status_d;
            err_pulse   <= err_pulse_d;
            cycle_count <= cycle_count_d;
            in_sync     <= in_sync_d;
        end
    end

    assign phase = state_q;

`ifdef TLM_DWELL_LOG_EN
    // Record the dwell of each phase left through its legal successor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_dwell <= '0;
            last_phase <= 2'b00;
        end else if (phase_exit) begin
            last_dwell <= dwell_q;
            last_phase <= state_q;
        end
    end
`else
    logic unused_log;
    assign unused_log = phase_exit;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed table-driven bench for traffic_light_monitor, plus hand sequences for async reset
// and the optional dwell log (TLM_DWELL_LOG_EN).
module tb_traffic_light_monitor;

    localparam int unsigned DW_W  = 8;
    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       light;
    logic             clear_err;
    logic [1:0]       phase;
    logic [3:0]       err_status;
    logic             err_pulse;
    logic [CNT_W-1:0] cycle_count;
    logic             in_sync;
`ifdef TLM_DWELL_LOG_EN
    logic [DW_W-1:0]  last_dwell;
    logic [1:0]       last_phase;
`endif

    traffic_light_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .light       (light),
        .clear_err   (clear_err),
        .phase       (phase),
        .err_status  (err_status),
        .err_pulse   (err_pulse),
        .cycle_count (cycle_count),
        .in_sync     (in_sync)
`ifdef TLM_DWELL_LOG_EN
        ,
        .last_dwell  (last_dwell),
        .last_phase  (last_phase)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic [2:0]       light;
        logic             clr;
        logic [1:0]       ph;
        logic [3:0]       err;
        logic             pulse;
        logic [CNT_W-1:0] cnt;
        logic             sync;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input int n, input logic rst, input logic [2:0] l, input logic clr,
                       input logic [1:0] ph, input logic [3:0] err, input logic pulse,
                       input logic [CNT_W-1:0] cnt, input logic sync);
        vec_t t;
        for (int i = 0; i < n; i++) begin
            t.rst   = rst && (i == 0);
            t.light = l;
            t.clr   = clr;
            t.ph    = ph;
            t.err   = err;
            t.pulse = pulse;
            t.cnt   = cnt;
            t.sync  = sync;
            vecs.push_back(t);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        light     = 3'b000;
        clear_err = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic step(input logic [2:0] l, input logic clr);
        light     = l;
        clear_err = clr;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
    endtask

    task automatic check_outs(input string name, input logic [1:0] ph, input logic [3:0] err,
                              input logic pulse, input logic [CNT_W-1:0] cnt, input logic sync);
        checks++;
        if (phase !== ph || err_status !== err || err_pulse !== pulse ||
            cycle_count !== cnt || in_sync !== sync) begin
            errors++;
            $display("FAIL %s got phase=%b err=%b pulse=%b cnt=%0d sync=%b want phase=%b err=%b pulse=%b cnt=%0d sync=%b",
                     name, phase, err_status, err_pulse, cycle_count, in_sync,
                     ph, err, pulse, cnt, sync);
        end
    endtask

    initial begin
        // Full legal cycle
        add(5, 1'b1, R, 1'b0, 2'b00, 4'b0000, 1'b0, 16'd0, 1'b1);
        add(5, 1'b0, G, 1'b0, 2'b01, 4'b0000, 1'b0, 16'd0, 1'b1);
        add(3, 1'b0, Y, 1'b0, 2'b10, 4'b0000, 1'b0, 16'd0, 1'b1);
        add(1, 1'b0, R, 1'b0, 2'b00, 4'b0000, 1'b0, 16'd1, 1'b1);
        // Order error, SYNC ignores GREEN, code error in SYNC, clear with re-sync
        add(5, 1'b1, R, 1'b0, 2'b00, 4'b0000, 1'b0, 16'd0, 1'b1);
        add(1, 1'b0, Y, 1'b0, 2'b11, 4'b0010, 1'b1, 16'd0, 1'b0);
        add(1, 1'b0, G, 1'b0, 2'b11, 4'b0010, 1'b0, 16'd0, 1'b0);
        add(1, 1'b0, 3'b000, 1'b0, 2'b11, 4'b0011, 1'b1, 16'd0, 1'b0);
        add(1, 1'b0, R, 1'b1, 2'b00, 4'b0000, 1'b0, 16'd0, 1'b1);
        // Short GREEN, re-sync, then code error with simultaneous clear
        add(3, 1'b0, R, 1'b0, 2'b00, 4'b0000, 1'b0, 16'd0, 1'b1);
        add(2, 1'b0, G, 1'b0, 2'b01, 4'b0000, 1'b0, 16'd0, 1'b1);
        add(1, 1'b0, Y, 1'b0, 2'b11, 4'b0100, 1'b1, 16'd0, 1'b0);
        add(5, 1'b0, R, 1'b0, 2'b00, 4'b0100, 1'b0, 16'd0, 1'b1);
        add(1, 1'b0, 3'b110, 1'b1, 2'b11, 4'b0001, 1'b1, 16'd0, 1'b0);
        // RED overstay: long on 9th sample, 10th RED starts tracking again
        add(8, 1'b1, R, 1'b0, 2'b00, 4'b0000, 1'b0, 16'd0, 1'b1);
        add(1, 1'b0, R, 1'b0, 2'b11, 4'b1000, 1'b1, 16'd0, 1'b0);
        add(1, 1'b0, R, 1'b0, 2'b00, 4'b1000, 1'b0, 16'd0, 1'b1);
        // Exact MIN cycle, exact MAX cycle, then RED one short of MIN
        add(4, 1'b1, R, 1'b0, 2'b00, 4'b0000, 1'b0, 16'd0, 1'b1);
        add(4, 1'b0, G, 1'b0, 2'b01, 4'b0000, 1'b0, 16'd0, 1'b1);
        add(2, 1'b0, Y, 1'b0, 2'b10, 4'b0000, 1'b0, 16'd0, 1'b1);
        add(8, 1'b0, R, 1'b0, 2'b00, 4'b0000, 1'b0, 16'd1, 1'b1);
        add(8, 1'b0, G, 1'b0, 2'b01, 4'b0000, 1'b0, 16'd1, 1'b1);
        add(6, 1'b0, Y, 1'b0, 2'b10, 4'b0000, 1'b0, 16'd1, 1'b1);
        add(3, 1'b0, R, 1'b0, 2'b00, 4'b0000, 1'b0, 16'd2, 1'b1);
        add(1, 1'b0, G, 1'b0, 2'b11, 4'b0100, 1'b1, 16'd2, 1'b0);
        add(1, 1'b0, G, 1'b1, 2'b11, 4'b0000, 1'b0, 16'd2, 1'b0);

        do_reset();
        check_outs("reset_state", 2'b11, 4'b0000, 1'b0, 16'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].light, vecs[i].clr);
            check_outs($sformatf("vec%0d", i), vecs[i].ph, vecs[i].err,
                       vecs[i].pulse, vecs[i].cnt, vecs[i].sync);
        end

        // Asynchronous reset in the middle of GREEN, with a nonzero cycle count
        do_reset();
        for (int i = 0; i < 5; i++) step(R, 1'b0);
        for (int i = 0; i < 5; i++) step(G, 1'b0);
        for (int i = 0; i < 3; i++) step(Y, 1'b0);
        for (int i = 0; i < 5; i++) step(R, 1'b0);
        for (int i = 0; i < 2; i++) step(G, 1'b0);
        check_outs("pre_async_reset", 2'b01, 4'b0000, 1'b0, 16'd1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_outs("async_reset", 2'b11, 4'b0000, 1'b0, 16'd0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifdef TLM_DWELL_LOG_EN
        checks++;
        if (last_dwell !== '0 || last_phase !== 2'b00) begin
            errors++;
            $display("FAIL log_reset got dwell=%0d phase=%b want dwell=0 phase=00", last_dwell, last_phase);
        end
        for (int i = 0; i < 6; i++) step(R, 1'b0);
        step(G, 1'b0);
        checks++;
        if (last_dwell !== DW_W'(6) || last_phase !== 2'b00) begin
            errors++;
            $display("FAIL log_red6 got dwell=%0d phase=%b want dwell=6 phase=00", last_dwell, last_phase);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
